servo_pwm_array: RTL
====================

# servo_pwm_array

Parametrised multi-channel servo pulse generator. Takes per-channel FP16 angle commands (degrees) and converts them with linear interpolation, not coarse 10° buckets, into pulse widths in clock cycles. Generates one PWM output per channel inside a shared frame period. Width changes are applied only at frame boundaries, with optional per-frame slew limiting. Sits between the joint-angle command logic and the servo output pins of the manipulator.

## Interface
Parameters:
- CHANNELS, 4: number of servo outputs (1..16).
- PERIOD_CYCLES, 1000000: frame length in clocks (20 ms at 50 MHz).
- MIN_CYCLES, 25000: pulse width at 0°.
- MAX_CYCLES, 125000: pulse width at 180°.
- STEP_MAX, 0: max width change per channel per frame in cycles; 0 = no limit.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  PWM generation enable.
- wr_en  in  1  angle write strobe, one cycle.
- wr_ch  in  clog2(CHANNELS) (min 1)  target channel.
- wr_angle  in  16  IEEE-754 half-precision angle in degrees.
- pwm  out  CHANNELS  servo pulse outputs, registered.
- frame_start  out  1  one-cycle pulse when the frame counter is 0.
- angle_err  out  CHANNELS  sticky per-channel flag for NaN/Inf commands.

## Operation
- **Angle decode (stage 1).**
  - Convert wr_angle to unsigned Q8.4 degrees (deg_q4).
  - Sign=1 → 0. Exponent=0 (zero/subnormal) → 0.
  - Exponent=31 → invalid: target unchanged, angle_err[wr_ch] set.
  - Normal values: truncate (1.m × 2^(e−15)) to 1/16°, then clamp to 180° (2880).
- **Width calc (stage 2).**
  - width = MIN_CYCLES + ((deg_q4 × K) >> 12), where K = round((MAX_CYCLES−MIN_CYCLES)×256/180), i.e. 142222 at defaults.
  - Result clamped to MAX_CYCLES.
  - Product is 30 bits; target registers are CW = clog2(PERIOD_CYCLES+1) bits.
  - Result is written to target[wr_ch].
  - A valid write clears angle_err[wr_ch].
- **Channel range.** wr_ch ≥ CHANNELS: write ignored entirely.
- **Frame counter.**
  - Counts 0..PERIOD_CYCLES−1, then wraps to 0.
  - frame_start = (count==0) && enable.
- **Frame update.** At count==PERIOD_CYCLES−1, each active[i] moves toward target[i]:
  - STEP_MAX=0, or |target−active| ≤ STEP_MAX: active ← target.
  - Otherwise: active ± STEP_MAX.
- **Output.** pwm[i] is registered: pwm[i] ← enable && (count < active[i]).
- **enable low.** Counter held at 0, pwm all 0, writes still accepted. The first frame starts at the cycle enable is sampled high.
- **Simultaneous write and frame update.** The update uses the target value present before the write. The write takes effect at the following boundary.
- **Back-to-back writes.** Allowed every cycle; pipeline fully pipelined.
- **Reset values.**
  - count = 0; pwm = 0; frame_start = 0; angle_err = 0.
  - target = active = width for 90° (74999 at defaults).
- **Reset mid-frame.** Outputs return to the reset values on the cycle after rst_n is sampled low; in-flight writes are discarded.

## Timing
- Write latency: wr_en in cycle N → target updated at the edge ending cycle N+1 (2-stage pipeline).
- Target → visible width: next frame boundary after the target is written.
- pwm is one cycle behind count: rises in the cycle after count==0 and stays high for exactly active[i] cycles.
- frame_start is asserted in the same cycle count==0.

## Structure
- Shared package servo_pkg holds:
  - FP16 field widths and the exponent constants (bias 15, all-ones 31).
  - Q4 180° limit (2880).
  - A function computing K from MIN/MAX.
- Sub-module fp16_to_deg_q4: combinational FP16 → clamped Q8.4 degrees, plus an invalid flag; registered by the parent as stage 1.
- Parent holds the multiply stage, target/active arrays, frame counter and slew logic.

## Test plan
- Reset, then enable=1 → all pwm high for 74999 cycles per frame; frame_start every 1000000 cycles.
- Write ch0=0x0000 (0°), ch1=0x55A0 (90°), ch2=0x59A0 (180°), ch3=0x5A40 (200°) → widths 25000, 74999, 124999, 124999 from the next frame.
- Write ch0=0xC900 (−10°) → 25000. Write ch1=0x7C00 (Inf) → width unchanged, angle_err[1]=1. Write ch1=0x55A0 → angle_err[1]=0.
- STEP_MAX=5000, write ch0=0x0000 from reset → widths 69999, 64999 … 29999, then 25000 on the 10th frame.
- Write at count==PERIOD_CYCLES−1 → not applied that boundary, applied at the next. Write with wr_ch=CHANNELS → no change anywhere.
- rst_n low mid-pulse → pwm=0 next cycle, count=0, targets back to 74999. enable low → pwm=0 and counter held.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants and helpers for the servo pulse generator.
package servo_pkg;

    localparam int FP16_EXP_W   = 5;
    localparam int FP16_MAN_W   = 10;
    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_MAX = 31;

    // {1,m} * 2^(e-ALIGN_EXP) gives the angle in 1/16 degree units.
    localparam int ALIGN_EXP = FP16_BIAS + FP16_MAN_W - 4;
    // From this exponent upward the angle is >= 256 deg and always saturates.
    localparam int SAT_EXP   = ALIGN_EXP + 2;

    localparam int              DEG_W      = 12;
    localparam logic [DEG_W-1:0] DEG_Q4_180 = 12'd2880;
    localparam int              DEG_Q4_90  = 1440;

    localparam int PROD_W   = 44;
    localparam int SCALE_SH = 12;

    typedef struct packed {
        logic             valid;
        logic             invalid;
        logic [DEG_W-1:0] deg_q4;
    } stage1_t;

    // Cycles per 1/16 degree, scaled by 2^12 (256 * 16), rounded to nearest.
    function automatic longint calc_k(input longint min_cycles, input longint max_cycles);
        return ((max_cycles - min_cycles) * 256 + 90) / 180;
    endfunction

endpackage

// File: rtl/fp16_to_deg_q4.sv
// Combinational FP16 degrees -> unsigned Q8.4 degrees clamped to 180.
module fp16_to_deg_q4
    import servo_pkg::*;
(
    input  logic [15:0]      angle,
    output logic [DEG_W-1:0] deg_q4,
    output logic             invalid
);

    logic                  sign;
    logic [FP16_EXP_W-1:0] expo;
    logic [12:0]           mant_ext;
    logic [12:0]           shifted;

    assign sign     = angle[15];
    assign expo     = angle[14:10];
    assign mant_ext = {2'b01, angle[9:0]};

    // Decode: NaN/Inf flagged, negatives and zero/subnormal floor to 0, rest truncated and clamped.
    always_comb begin
        invalid = 1'b0;
        deg_q4  = '0;
        shifted = '0;
        if (expo == FP16_EXP_W'(FP16_EXP_MAX)) begin
            invalid = 1'b1;
        end else if (sign || (expo == '0)) begin
            deg_q4 = '0;
        end else if (expo >= FP16_EXP_W'(SAT_EXP)) begin
            deg_q4 = DEG_Q4_180;
        end else begin
            if (expo >= FP16_EXP_W'(ALIGN_EXP))
                shifted = mant_ext << (expo - FP16_EXP_W'(ALIGN_EXP));
            else
                shifted = mant_ext >> (FP16_EXP_W'(ALIGN_EXP) - expo);
            deg_q4 = (shifted > 13'(DEG_Q4_180)) ? DEG_Q4_180 : shifted[DEG_W-1:0];
        end
    end

endmodule

// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM: angle write pipeline, frame counter, slew-limited widths.
module servo_pwm_array
    import servo_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int PERIOD_CYCLES = 1000000,
    parameter int MIN_CYCLES    = 25000,
    parameter int MAX_CYCLES    = 125000,
    parameter int STEP_MAX      = 0
)(
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            enable,
    input  logic                                            wr_en,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_ch,
    input  logic [15:0]                                     wr_angle,
    output logic [CHANNELS-1:0]                             pwm,
    output logic                                            frame_start,
    output logic [CHANNELS-1:0]                             angle_err
);

    localparam int              CHW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int              CW          = $clog2(PERIOD_CYCLES + 1);
    localparam longint          K           = calc_k(MIN_CYCLES, MAX_CYCLES);
    localparam longint          RESET_WIDTH = MIN_CYCLES + ((DEG_Q4_90 * K) >> SCALE_SH);
    localparam logic [CW-1:0]   RESET_W     = CW'(RESET_WIDTH);
    localparam logic [CW-1:0]   LAST        = CW'(PERIOD_CYCLES - 1);
    localparam logic [CW-1:0]   STEP        = CW'(STEP_MAX);

    logic [DEG_W-1:0]  dec_deg;
    logic              dec_invalid;
    stage1_t           s1;
    logic [CHW-1:0]    s1_ch;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] width_full;
    logic [CW-1:0]     width;
    logic [CW-1:0]     count;
    logic [CW-1:0]     target      [CHANNELS];
    logic [CW-1:0]     active      [CHANNELS];
    logic [CW-1:0]     next_active [CHANNELS];

    fp16_to_deg_q4 u_dec (
        .angle   (wr_angle),
        .deg_q4  (dec_deg),
        .invalid (dec_invalid)
    );

    // Stage 1: register the decoded angle; out-of-range channels never enter the pipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= '0;
            s1_ch <= '0;
        end else begin
            s1.valid   <= wr_en && (int'(wr_ch) < CHANNELS);
            s1.invalid <= dec_invalid;
            s1.deg_q4  <= dec_deg;
            s1_ch      <= wr_ch;
        end
    end

    // Stage 2 arithmetic: linear interpolation from degrees to cycles, clamped at the top.
    always_comb begin
        prod       = PROD_W'(s1.deg_q4) * PROD_W'(K);
        width_full = PROD_W'(MIN_CYCLES) + (prod >> SCALE_SH);
        width      = (width_full > PROD_W'(MAX_CYCLES)) ? CW'(MAX_CYCLES) : width_full[CW-1:0];
    end

    // Stage 2 write-back: valid command loads target and clears the error; NaN/Inf only flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) target[i] <= RESET_W;
            angle_err <= '0;
        end else if (s1.valid) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (s1_ch == CHW'(i)) begin
                    if (s1.invalid) begin
                        angle_err[i] <= 1'b1;
                    end else begin
                        target[i]    <= width;
                        angle_err[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Frame counter, parked at zero while disabled so the first frame starts on enable.
    always_ff @(posedge clk) begin
        if (!rst_n)          count <= '0;
        else if (!enable)    count <= '0;
        else if (count == LAST) count <= '0;
        else                 count <= count + 1'b1;
    end

    // Next active width: jump to target, or move by at most STEP toward it.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            next_active[i] = target[i];
            if (STEP_MAX != 0) begin
                if ((target[i] > active[i]) && ((target[i] - active[i]) > STEP))
                    next_active[i] = active[i] + STEP;
                else if ((active[i] > target[i]) && ((active[i] - target[i]) > STEP))
                    next_active[i] = active[i] - STEP;
            end
        end
    end

    // Active widths only change on the last cycle of a frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) active[i] <= RESET_W;
        end else if (enable && (count == LAST)) begin
            for (int i = 0; i < CHANNELS; i++) active[i] <= next_active[i];
        end
    end

    // Registered pulse outputs, one cycle behind the counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) pwm[i] <= enable && (count < active[i]);
        end
    end

    assign frame_start = rst_n && enable && (count == '0);

endmodule
